// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The master side (controller) takes instruction fields and the zero flag, and drives every select and enable.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [2:0] alu_control;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_control, state
  );

  modport slave (
    output op, funct, zero,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_control, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Per-state controls are registered alongside the state; only funct-driven ALU op, zero-driven pc_en and reset gating are combinational.
module mips_multicycle_ctrl (
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM4 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] pc_src;
    logic             pc_write;
    logic             branch;
    logic [ALU_W-1:0] alu_control;
  } ctrl_t;

  state_t           r_state;
  ctrl_t            r_ctrl;
  state_t           w_next;
  logic [ALU_W-1:0] w_alu_exec;

  // Instruction sequencing; unknown opcodes fall back to FETCH and act as a 2-cycle NOP.
  function automatic state_t f_next(input state_t s, input logic [OP_W-1:0] op);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEXEC;
          OP_J:         n = S_JUMP;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:   n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  n = S_MEMWB;
      S_EXECUTE:  n = S_ALUWB;
      S_ADDIEXEC: n = S_ADDIWB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  // Moore control word of a state; anything not set stays 0 with the ALU on add.
  function automatic ctrl_t f_decode(input state_t s);
    ctrl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:   c.alu_src_b = SRCB_IMM4;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_REG;
        c.alu_control = ALU_SUB;
        c.pc_src      = PCSRC_ALUOUT;
        c.branch      = 1'b1;
      end
      S_ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      default:    c.pc_src = PCSRC_ALU;
    endcase
    return c;
  endfunction

  function automatic logic [ALU_W-1:0] f_funct_alu(input logic [OP_W-1:0] fn);
    logic [ALU_W-1:0] a;
    case (fn)
      FN_ADD:  a = ALU_ADD;
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  assign w_next     = f_next(r_state, bus.op);
  assign w_alu_exec = f_funct_alu(bus.funct);

  // State and its control word advance together, so outputs track the state with no decode delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= f_decode(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_decode(w_next);
    end
  end

  assign bus.state       = r_state;
  assign bus.iord        = r_ctrl.iord;
  assign bus.reg_dst     = r_ctrl.reg_dst;
  assign bus.mem_to_reg  = r_ctrl.mem_to_reg;
  assign bus.alu_src_a   = r_ctrl.alu_src_a;
  assign bus.alu_src_b   = r_ctrl.alu_src_b;
  assign bus.pc_src      = r_ctrl.pc_src;
  assign bus.alu_control = (r_state == S_EXECUTE) ? w_alu_exec : r_ctrl.alu_control;

  // Reset masks every write so an aborted instruction leaves no side effects.
  assign bus.ir_write    = r_ctrl.ir_write  & ~reset;
  assign bus.reg_write   = r_ctrl.reg_write & ~reset;
  assign bus.mem_write   = r_ctrl.mem_write & ~reset;
  assign bus.pc_en       = (r_ctrl.pc_write | (r_ctrl.branch & bus.zero)) & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed plan steps followed by random instruction streams.
module tb_mips_multicycle_ctrl;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_vec();
    return {1'b0, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_en, bus.alu_control};
  endfunction

  // Reference: state visit order of one instruction, starting at FETCH.
  function automatic iq_t seq_for(input logic [5:0] op);
    iq_t q;
    case (op)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
      default:   q = '{0, 1};
    endcase
    return q;
  endfunction

  // Reference: expected outputs for a state code, straight from the per-state control table.
  function automatic logic [15:0] exp_out(input int code, input logic [5:0] fn, input logic z, input logic rst);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pcen = 0;
    sb = 2'd0; ps = 2'd0; alu = 3'b010;
    case (code)
      0:  begin irw = 1; pcen = 1; sb = 2'd1; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin
        sa = 1;
        if (fn == 6'h22) alu = 3'b110;
        else if (fn == 6'h24) alu = 3'b000;
        else if (fn == 6'h25) alu = 3'b001;
        else if (fn == 6'h2a) alu = 3'b111;
        else alu = 3'b010;
      end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; ps = 2'd1; pcen = z; end
      9:  begin sa = 1; sb = 2'd2; end
      10: rw = 1;
      11: begin ps = 2'd2; pcen = 1; end
      default: ;
    endcase
    if (rst) begin irw = 0; rw = 0; mw = 0; pcen = 0; end
    return {1'b0, iord, mw, irw, rd, m2r, rw, sa, sb, ps, pcen, alu};
  endfunction

  // Runs one instruction from FETCH; entered and left at posedge+1. zmode<0 randomises zero each cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at);
    iq_t seq;
    seq       = seq_for(op);
    bus.op    = op;
    bus.funct = fn;
    for (int i = 0; i < seq.size(); i++) begin
      bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (i == abort_at) reset = 1'b1;
      @(negedge clk);
      check({tag, "_state"}, {12'd0, bus.state}, 16'(seq[i]));
      check({tag, "_ctrl"}, obs_vec(), exp_out(seq[i], fn, bus.zero, reset));
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        return;
      end
    end
  endtask

  logic [5:0] ops[7];
  logic [5:0] fns[6];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

    reset     = 1'b1;
    bus.op    = 6'b100011;
    bus.funct = 6'd0;
    bus.zero  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst1_state", {12'd0, bus.state}, 16'd0);
    check("rst1_ctrl", obs_vec(), exp_out(0, 6'd0, 1'b0, 1'b1));
    @(posedge clk);
    @(negedge clk);
    check("rst2_state", {12'd0, bus.state}, 16'd0);
    check("rst2_ctrl", obs_vec(), exp_out(0, 6'd0, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr("lw", 6'b100011, 6'd0, -1, -1);
    run_instr("sw", 6'b101011, 6'd0, -1, -1);
    for (int k = 0; k < 6; k++) run_instr($sformatf("rtype%0d", k), 6'b000000, fns[k], -1, -1);
    run_instr("addi", 6'b001000, 6'd0, -1, -1);
    run_instr("beq_z1", 6'b000100, 6'd0, 1, -1);
    run_instr("beq_z0", 6'b000100, 6'd0, 0, -1);
    run_instr("j", 6'b000010, 6'd0, -1, -1);
    run_instr("unk", 6'b111111, 6'd0, -1, -1);
    run_instr("sw_abort", 6'b101011, 6'd0, -1, 3);
    run_instr("post_abort", 6'b000010, 6'd0, -1, -1);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int         ab;
      op = ops[$urandom_range(0, 6)];
      if (op == 6'b111111) op = 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr("rand", op, fn, -1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
